// File: rtl/life_pkg.sv
// life_pkg: shared types and constants for the Game of Life grid path.
//   GRID_ROWS / GRID_COLS / GRID_W : grid geometry (8 x 8 = 64 cells)
//   grid_t                         : one generation, bit r*8+c is row r, column c
//   scan_state_t                   : scan driver FSM states
//   grid_row()                     : extracts the 8 column bits of one row
package life_pkg;

  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 8;
  localparam int GRID_W    = 64;

  typedef logic [GRID_W-1:0] grid_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // Column bits of row r; the index {r, 3'b000} is r*8 without a multiplier.
  function automatic logic [GRID_COLS-1:0] grid_row(input grid_t g, input logic [2:0] r);
    grid_row = g[{r, 3'b000} +: GRID_COLS];
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: up-counter with synchronous clear, count enable and a
// runtime terminal value. Counts 0..last, wraps to 0 after last while enabled.
//   clk, reset  : clock, asynchronous active-low reset
//   clear       : force the count to 0 on the next edge (wins over en)
//   en          : advance the count
//   last        : terminal value (phase length - 1)
//   count_next  : value the counter takes at the next edge
//   tc          : count == last
module dwell_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count_next,
  output logic         tc
);

  logic [W-1:0] count_r;

  assign tc = (count_r == last);

  // Next count: clear dominates, then wrap-at-terminal increment, else hold.
  always_comb begin
    count_next = count_r;
    if (clear) begin
      count_next = {W{1'b0}};
    end else if (en) begin
      if (tc) begin
        count_next = {W{1'b0}};
      end else begin
        count_next = count_r + W'(1'b1);
      end
    end else begin
      count_next = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else begin
      count_r <= count_next;
    end
  end

endmodule

// File: rtl/grid_scan_driver.sv
// grid_scan_driver: takes 64-bit Game of Life generations and scans them out
// row by row to an 8x8 LED matrix. A new generation is held in a pending
// buffer and only becomes visible at a frame boundary, so frames never tear.
//
// Build option: define SCAN_BLANKING_EN to insert BLANK_CYCLES all-off cycles
// after every row (including row 7) to suppress ghosting.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   grid       : generation from the core, bit r*8+c = row r, column c
//   grid_valid : one-cycle strobe, grid holds a new generation
//   en         : scan enable; low blanks the outputs and freezes the scan
//   row_sel    : one-hot row drive, active high
//   col_data   : column data of the selected row
//   frame_done : high during the final scan cycle of row 7
//   grid_drop  : pulse when an undisplayed pending grid is overwritten
module grid_scan_driver
  import life_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] grid,
  input  logic        grid_valid,
  input  logic        en,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_done,
  output logic        grid_drop
);

  // One counter serves both phases, so it is sized for the longer one.
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
`ifdef SCAN_BLANKING_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

  scan_state_t      state_r, state_s;
  logic [2:0]       row_r, row_s;
  grid_t            active_r, active_s;
  grid_t            pending_r, pending_s;
  logic             pending_valid_r, pending_valid_s;
  logic             grid_drop_r, grid_drop_s;
  logic             frame_done_r, frame_done_s;
  logic [7:0]       row_sel_r, row_sel_s;
  logic [7:0]       col_data_r, col_data_s;
  logic             swap_s;
  logic             cnt_clr_s, cnt_en_s, cnt_tc_s;
  logic [CNT_W-1:0] cnt_last_s, cnt_next_s;

  // Terminal value depends only on the current phase.
`ifdef SCAN_BLANKING_EN
  assign cnt_last_s = (state_r == BLANK) ? BLANK_LAST : DWELL_LAST;
`else
  assign cnt_last_s = DWELL_LAST;
`endif

  dwell_counter #(
    .W (CNT_W)
  ) u_dwell_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clr_s),
    .en         (cnt_en_s),
    .last       (cnt_last_s),
    .count_next (cnt_next_s),
    .tc         (cnt_tc_s)
  );

  // FSM next state, row advance, pending capture and frame-end swap.
  always_comb begin
    state_s         = state_r;
    row_s           = row_r;
    active_s        = active_r;
    pending_s       = pending_r;
    pending_valid_s = pending_valid_r;
    grid_drop_s     = 1'b0;
    cnt_clr_s       = 1'b0;
    cnt_en_s        = 1'b0;
    swap_s          = 1'b0;

    case (state_r)
      IDLE: begin
        if (grid_valid) begin
          active_s  = grid;
          row_s     = 3'd0;
          cnt_clr_s = 1'b1;
          state_s   = SCAN;
        end else begin
          state_s   = IDLE;
        end
      end
      SCAN: begin
        if (en) begin
          if (cnt_tc_s) begin
            cnt_clr_s = 1'b1;
            // Row 7 wraps to 0 through the 3-bit add; that is the frame end.
            row_s     = row_r + 3'd1;
            swap_s    = (row_r == 3'd7);
`ifdef SCAN_BLANKING_EN
            state_s   = BLANK;
`else
            state_s   = SCAN;
`endif
          end else begin
            cnt_en_s  = 1'b1;
          end
        end else begin
          cnt_en_s = 1'b0;
        end
      end
`ifdef SCAN_BLANKING_EN
      BLANK: begin
        // Row was already advanced on entry, so SCAN resumes at the next row.
        if (en) begin
          if (cnt_tc_s) begin
            cnt_clr_s = 1'b1;
            state_s   = SCAN;
          end else begin
            cnt_en_s  = 1'b1;
          end
        end else begin
          cnt_en_s = 1'b0;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase

    // A grid arriving on the swap cycle bypasses pending and is never a drop.
    if (swap_s) begin
      if (grid_valid) begin
        active_s = grid;
      end else if (pending_valid_r) begin
        active_s = pending_r;
      end else begin
        active_s = active_r;
      end
      pending_valid_s = 1'b0;
    end else if (grid_valid && (state_r != IDLE)) begin
      pending_s       = grid;
      pending_valid_s = 1'b1;
      grid_drop_s     = pending_valid_r;
    end else begin
      pending_valid_s = pending_valid_r;
    end
  end

  // Output images computed from next-state values so the registers line up
  // with the state they describe.
  always_comb begin
    row_sel_s    = 8'h00;
    col_data_s   = 8'h00;
    frame_done_s = 1'b0;
    if (state_s == SCAN) begin
      row_sel_s    = 8'h01 << row_s;
      col_data_s   = grid_row(active_s, row_s);
      frame_done_s = (row_s == 3'd7) && (cnt_next_s == DWELL_LAST);
    end else begin
      row_sel_s    = 8'h00;
      col_data_s   = 8'h00;
      frame_done_s = 1'b0;
    end
  end

  // State, grid buffers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      row_r           <= 3'd0;
      active_r        <= 64'd0;
      pending_r       <= 64'd0;
      pending_valid_r <= 1'b0;
      grid_drop_r     <= 1'b0;
      frame_done_r    <= 1'b0;
      row_sel_r       <= 8'h00;
      col_data_r      <= 8'h00;
    end else begin
      state_r         <= state_s;
      row_r           <= row_s;
      active_r        <= active_s;
      pending_r       <= pending_s;
      pending_valid_r <= pending_valid_s;
      grid_drop_r     <= grid_drop_s;
      frame_done_r    <= frame_done_s;
      row_sel_r       <= row_sel_s;
      col_data_r      <= col_data_s;
    end
  end

  // en only masks the matrix drive; the scan position stays where it is.
  assign row_sel    = en ? row_sel_r  : 8'h00;
  assign col_data   = en ? col_data_r : 8'h00;
  assign frame_done = frame_done_r;
  assign grid_drop  = grid_drop_r;

endmodule

// File: doc/grid_scan_driver.md
# grid_scan_driver

Consumer end of the Game of Life grid interface: accepts each new 64-bit generation from the evolution core and scans it out row by row to an 8x8 LED matrix. Holds a pending-grid buffer so a new generation is only shown at a frame boundary, which keeps frames from tearing. Sits between the Game of Life top level and the board's matrix row/column pins.

## Interface
- DWELL_CYCLES, 1000: clock cycles each row is driven; must be ≥ 2.
- BLANK_CYCLES, 4: all-off cycles between rows; only used with the blanking macro; must be ≥ 1.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- grid  input  64  generation from the core; bit r*8+c is row r, column c.
- grid_valid  input  1  one-cycle strobe: `grid` holds a new generation.
- en  input  1  scan enable; low blanks outputs and freezes the scan position.
- row_sel  output  8  one-hot row drive, active high.
- col_data  output  8  column data for the selected row: col_data[c] = active[r*8+c].
- frame_done  output  1  one-cycle pulse at the end of the last dwell of row 7.
- grid_drop  output  1  one-cycle pulse when a pending grid is overwritten before it is displayed.

## Operation
- Registers:
  - `active`: grid being shown.
  - `pending` and `pending_valid`: next grid waiting for a frame boundary.
  - `row`: 3-bit row index.
  - `cnt`: dwell/blank counter.
- FSM states:
  - IDLE: outputs zero. On grid_valid, load `active` ← grid, row ← 0, cnt ← 0, go to SCAN.
  - SCAN: row_sel = 1<<row and col_data driven. cnt counts up to DWELL_CYCLES-1.
    - When the count ends on row < 7: go to BLANK if the macro is defined, else row+1 directly.
    - When the count ends on row 7: assert frame_done, perform the swap, row ← 0, then go to BLANK or SCAN.
  - BLANK (macro only): row_sel = 0, col_data = 0 for BLANK_CYCLES, then SCAN at the next row.
- Capture: grid_valid outside IDLE writes pending ← grid and sets pending_valid. If pending_valid is already set and not being consumed that cycle, pulse grid_drop. Newest grid wins.
- Swap at frame end:
  - If grid_valid is high that same cycle, active ← grid; the incoming grid bypasses `pending`.
  - Otherwise, if pending_valid is set, active ← pending.
  - In both cases pending_valid is cleared. No drop is reported for a grid_valid that coincides with the swap.
- en low:
  - row_sel = 0 and col_data = 0 (combinationally gated).
  - cnt, row and the FSM state hold.
  - Capture still operates.
  - An IDLE→SCAN load on grid_valid still happens.
- The module never returns to IDLE except through reset.

## Timing
- Reset (asynchronous, while reset = 0):
  - row_sel = 0, col_data = 0, frame_done = 0, grid_drop = 0.
  - active = 0, pending = 0, pending_valid = 0.
  - row = 0, cnt = 0, state = IDLE.
- Latency:
  - grid_valid in IDLE at edge k → row_sel = 8'h01 with row 0 data from edge k+1.
  - Each row occupies exactly DWELL_CYCLES cycles in SCAN.
  - Frame period: 8·DWELL_CYCLES cycles without the macro; 8·(DWELL_CYCLES+BLANK_CYCLES) with it.
- frame_done is high during the final SCAN cycle of row 7. The new `active` is visible from the next row-0 SCAN cycle.
- grid_drop is registered and asserts the cycle after the overwriting grid_valid.
- Reset asserted mid-frame aborts immediately to the reset values. Scanning restarts only on the next grid_valid.
- Outputs are registered, except for the en gating.

## Configuration
- SCAN_BLANKING_EN defined: BLANK state compiled in. BLANK_CYCLES all-off cycles follow every row, including row 7, to suppress ghosting.
- SCAN_BLANKING_EN undefined: BLANK state and BLANK_CYCLES logic absent. SCAN advances row-to-row back-to-back.

## Structure
- Shared package `life_pkg`:
  - GRID_ROWS = 8, GRID_COLS = 8, GRID_W = 64.
  - `grid_t` (logic [63:0]).
  - `scan_state_t` enum {IDLE, SCAN, BLANK}.
- One natural sub-module, `dwell_counter`: a parameterized up-counter with clear, enable and terminal-count output, sized with $clog2. It is reused for the dwell and blank phases.

## Test plan
All scenarios use DWELL_CYCLES=4, BLANK_CYCLES=2.
- Reset, no grid_valid for 50 cycles → row_sel = 0, col_data = 0, frame_done never pulses.
- grid_valid with grid = 64'h8040_2010_0804_0201 →
  - row_sel walks 01,02,04,…,80, 4 cycles each.
  - col_data per row = 01,02,04,08,10,20,40,80.
  - frame_done pulses every 32 cycles (48 with SCAN_BLANKING_EN, with a 2-cycle all-zero gap per row).
- Mid-frame (row 3) grid_valid with 64'hFFFF_FFFF_FFFF_FFFF → rows 3–7 still show the old grid; from the next row 0 every col_data = FF.
- Two grid_valids (64'h1, then 64'h3) in the same frame → grid_drop pulses once; the next frame shows row 0 col_data = 03.
- grid_valid coincident with the frame_done cycle, grid = 64'hAA → the next frame row 0 col_data = AA, no grid_drop.
- en low for 10 cycles during row 5 → outputs zero, row 5 resumes with its remaining dwell. Reset pulsed during row 6 → immediate zeros, IDLE until the next grid_valid.
